// File: rtl/ariane_dfx_ctrl_pkg.sv
// Shared types and constants for the Ariane DFX reconfiguration sequencer.
// State encoding is visible on state_o, so the values are fixed.
package ariane_dfx_ctrl_pkg;

    typedef enum logic [2:0] {
        DFX_IDLE     = 3'd0,
        DFX_SHUTDOWN = 3'd1,
        DFX_DECOUPLE = 3'd2,
        DFX_GRANT    = 3'd3,
        DFX_RESET    = 3'd4,
        DFX_RECOUPLE = 3'd5
    } dfx_state_e;

    localparam logic [15:0] DFX_CNT_SAT = 16'hFFFF;

    function automatic logic [15:0] dfx_sat_inc(input logic [15:0] val);
        return (val == DFX_CNT_SAT) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/ariane_dfx_timer.sv
// Loadable down-counter shared by every timed state of the DFX sequencer.
// Counts down to zero and holds there until reloaded.
module ariane_dfx_timer #(
    parameter int CntW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            zero_o
);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/ariane_dfx_ctrl.sv
// Sequencer driving the Ariane core DFX controls: quiesce, decouple, grant, RP reset, recouple.
// Define ARIANE_DFX_CTRL_STATS_EN to build the saturating sequence/timeout counters.
module ariane_dfx_ctrl
    import ariane_dfx_ctrl_pkg::*;
#(
    parameter int TimeoutCycles = 1024,
    parameter int RstCycles     = 16,
    parameter int SettleCycles  = 4,
    parameter int CntW          = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        reconfig_req_i,
    input  logic        reconfig_done_i,
    input  logic        shutdown_ack_i,
    input  logic        err_clr_i,
    output logic        shutdown_req_o,
    output logic        dfx_decouple_o,
    output logic        rp_reset_o,
    output logic        reconfig_grant_o,
    output logic        busy_o,
    output logic        timeout_err_o,
    output logic [2:0]  state_o,
    output logic [15:0] reconfig_cnt_o,
    output logic [15:0] timeout_cnt_o
);

    localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] RstLoad     = CntW'(RstCycles - 1);
    localparam logic [CntW-1:0] SettleLoad  = CntW'(SettleCycles - 1);

    dfx_state_e      state_q, state_d;
    logic            tmr_load, tmr_zero, forced_exit;
    logic [CntW-1:0] tmr_val;
    logic            err_q, err_d;
    logic            shutdown_req_q, shutdown_req_d;
    logic            decouple_q, decouple_d;
    logic            rp_reset_q, rp_reset_d;
    logic            grant_q, grant_d;
    logic            busy_q, busy_d;

    ariane_dfx_timer #(.CntW(CntW)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        forced_exit = 1'b0;
        case (state_q)
            DFX_IDLE: begin
                if (reconfig_req_i) begin
                    state_d  = DFX_SHUTDOWN;
                    tmr_load = 1'b1;
                    tmr_val  = TimeoutLoad;
                end
            end
            DFX_SHUTDOWN: begin
                // An ack arriving on the last timer cycle still counts as a clean quiesce.
                if (shutdown_ack_i || tmr_zero) begin
                    state_d     = DFX_DECOUPLE;
                    tmr_load    = 1'b1;
                    tmr_val     = SettleLoad;
                    forced_exit = !shutdown_ack_i;
                end
            end
            DFX_DECOUPLE: begin
                if (tmr_zero) begin
                    state_d = DFX_GRANT;
                end
            end
            DFX_GRANT: begin
                if (reconfig_done_i) begin
                    state_d  = DFX_RESET;
                    tmr_load = 1'b1;
                    tmr_val  = RstLoad;
                end
            end
            DFX_RESET: begin
                if (tmr_zero) begin
                    state_d  = DFX_RECOUPLE;
                    tmr_load = 1'b1;
                    tmr_val  = SettleLoad;
                end
            end
            DFX_RECOUPLE: begin
                if (tmr_zero) begin
                    state_d = DFX_IDLE;
                end
            end
            default: state_d = DFX_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state_o.
    always_comb begin
        shutdown_req_d = state_d inside {DFX_SHUTDOWN, DFX_DECOUPLE, DFX_GRANT, DFX_RESET};
        decouple_d     = state_d inside {DFX_DECOUPLE, DFX_GRANT, DFX_RESET};
        rp_reset_d     = (state_d == DFX_RESET);
        grant_d        = (state_d == DFX_GRANT);
        busy_d         = (state_d != DFX_IDLE);
        err_d          = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (forced_exit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= DFX_IDLE;
            err_q          <= 1'b0;
            shutdown_req_q <= 1'b0;
            decouple_q     <= 1'b0;
            rp_reset_q     <= 1'b0;
            grant_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            err_q          <= err_d;
            shutdown_req_q <= shutdown_req_d;
            decouple_q     <= decouple_d;
            rp_reset_q     <= rp_reset_d;
            grant_q        <= grant_d;
            busy_q         <= busy_d;
        end
    end

    assign shutdown_req_o   = shutdown_req_q;
    assign dfx_decouple_o   = decouple_q;
    assign rp_reset_o       = rp_reset_q;
    assign reconfig_grant_o = grant_q;
    assign busy_o           = busy_q;
    assign timeout_err_o    = err_q;
    assign state_o          = state_q;

`ifdef ARIANE_DFX_CTRL_STATS_EN
    logic [15:0] reconfig_cnt_q, reconfig_cnt_d;
    logic [15:0] timeout_cnt_q, timeout_cnt_d;

    always_comb begin
        reconfig_cnt_d = reconfig_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        if (state_q == DFX_RECOUPLE && state_d == DFX_IDLE) begin
            reconfig_cnt_d = dfx_sat_inc(reconfig_cnt_q);
        end
        if (forced_exit) begin
            timeout_cnt_d = dfx_sat_inc(timeout_cnt_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reconfig_cnt_q <= '0;
            timeout_cnt_q  <= '0;
        end else begin
            reconfig_cnt_q <= reconfig_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
        end
    end

    assign reconfig_cnt_o = reconfig_cnt_q;
    assign timeout_cnt_o  = timeout_cnt_q;
`else
    assign reconfig_cnt_o = '0;
    assign timeout_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_ariane_dfx_ctrl.sv
// Self-checking bench for ariane_dfx_ctrl with TimeoutCycles=16, RstCycles=4, SettleCycles=2.
// Expected per-cycle output vectors are queued per sequence and popped as the DUT advances.
module tb_ariane_dfx_ctrl;

    localparam int TO = 16;
    localparam int RC = 4;
    localparam int SC = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req = 1'b0;
    logic        done = 1'b0;
    logic        ack = 1'b0;
    logic        clr = 1'b0;
    logic        shutdown_req_o, dfx_decouple_o, rp_reset_o, reconfig_grant_o;
    logic        busy_o, timeout_err_o;
    logic [2:0]  state_o;
    logic [15:0] reconfig_cnt_o, timeout_cnt_o;

    int checks = 0;
    int failures = 0;
    logic [40:0] exp_q[$];
    logic        err_m = 1'b0;
    logic [15:0] rc_m = 16'd0;
    logic [15:0] tc_m = 16'd0;

    ariane_dfx_ctrl #(
        .TimeoutCycles (TO),
        .RstCycles     (RC),
        .SettleCycles  (SC),
        .CntW          (32)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .reconfig_req_i   (req),
        .reconfig_done_i  (done),
        .shutdown_ack_i   (ack),
        .err_clr_i        (clr),
        .shutdown_req_o   (shutdown_req_o),
        .dfx_decouple_o   (dfx_decouple_o),
        .rp_reset_o       (rp_reset_o),
        .reconfig_grant_o (reconfig_grant_o),
        .busy_o           (busy_o),
        .timeout_err_o    (timeout_err_o),
        .state_o          (state_o),
        .reconfig_cnt_o   (reconfig_cnt_o),
        .timeout_cnt_o    (timeout_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [40:0] pack_exp(input logic [2:0] st, input logic err,
                                             input logic [15:0] rc, input logic [15:0] tc);
        logic sr, dc, rr, gr, bz;
        sr = (st == 3'd1) || (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
        dc = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
        rr = (st == 3'd4);
        gr = (st == 3'd3);
        bz = (st != 3'd0);
        return {st, sr, dc, rr, gr, bz, err, rc, tc};
    endfunction

    function automatic logic [40:0] dut_vec();
        return {state_o, shutdown_req_o, dfx_decouple_o, rp_reset_o, reconfig_grant_o,
                busy_o, timeout_err_o, reconfig_cnt_o, timeout_cnt_o};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in an IDLE cycle; leaves positioned in the final IDLE cycle without ticking past it.
    // a: ack cycle (0 = never), d_off: done delay into GRANT, spur: stray done/req outside their window,
    // hold: keep req high on return to IDLE, clr_sd: pulse err_clr on the last SHUTDOWN cycle.
    task automatic run_seq(input int a, input int d_off, input bit spur, input bit hold,
                           input bit clr_sd, input string name);
        int s_end, dec_s, gr_s, d, rec_s, rs_s, last;
        bit forced;
        logic err_after;
        logic [15:0] rc_after, tc_after;
        logic [2:0] st;
        logic [40:0] got, want;
        forced = (a == 0) || (a > TO);
        s_end  = forced ? TO : a;
        dec_s  = s_end + 1;
        gr_s   = dec_s + SC;
        d      = gr_s + d_off;
        rs_s   = d + 1;
        rec_s  = rs_s + RC;
        last   = rec_s + SC;
        err_after = forced ? 1'b1 : (clr_sd ? 1'b0 : err_m);
        rc_after  = rc_m;
        tc_after  = tc_m;
`ifdef ARIANE_DFX_CTRL_STATS_EN
        rc_after = sat_inc(rc_m);
        if (forced) tc_after = sat_inc(tc_m);
`endif
        for (int c = 0; c <= last; c++) begin
            if (c == 0 || c == last) st = 3'd0;
            else if (c <= s_end)     st = 3'd1;
            else if (c < gr_s)       st = 3'd2;
            else if (c <= d)         st = 3'd3;
            else if (c < rec_s)      st = 3'd4;
            else                     st = 3'd5;
            exp_q.push_back(pack_exp(st, (c >= dec_s) ? err_after : err_m,
                                     (c == last) ? rc_after : rc_m,
                                     (c >= dec_s) ? tc_after : tc_m));
        end
        for (int c = 0; c <= last; c++) begin
            got  = dut_vec();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
            end
            req  = (c == 0) || (c == last && hold) || (spur && c == dec_s);
            ack  = (a != 0) && (c == a);
            done = (c == d) || (spur && (c == 0 || c == dec_s));
            clr  = clr_sd && (c == s_end);
            if (c != last) tick();
        end
        err_m = err_after;
        rc_m  = rc_after;
        tc_m  = tc_after;
        $display("seq %s: ack_cyc=%0d forced=%0d done_cyc=%0d idle_cyc=%0d", name, a, forced, d, last);
    endtask

    task automatic test_reset();
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 41'd0) begin
            failures++;
            $display("FAIL reset_async got=%h want=0", dut_vec());
        end
        tick();
        tick();
        checks++;
        if (dut_vec() !== 41'd0) begin
            failures++;
            $display("FAIL reset_held got=%h want=0", dut_vec());
        end
        rst_ni = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== 41'd0) begin
            failures++;
            $display("FAIL reset_release got=%h want=0", dut_vec());
        end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_err_clr();
        checks++;
        if (timeout_err_o !== err_m) begin
            failures++;
            $display("FAIL err_before_clr got=%b want=%b", timeout_err_o, err_m);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        err_m = 1'b0;
        checks++;
        if (dut_vec() !== pack_exp(3'd0, 1'b0, rc_m, tc_m)) begin
            failures++;
            $display("FAIL err_clr got=%h want=%h", dut_vec(), pack_exp(3'd0, 1'b0, rc_m, tc_m));
        end
        $display("err_clr: timeout_err_o=%b", timeout_err_o);
    endtask

    task automatic test_reset_mid();
        int i;
        i = 0;
        while (state_o != 3'd4 && i < 60) begin
            req  = (i == 0);
            ack  = (state_o == 3'd1);
            done = (state_o == 3'd3);
            tick();
            i++;
        end
        req = 1'b0; ack = 1'b0; done = 1'b0;
        checks++;
        if (state_o !== 3'd4 || rp_reset_o !== 1'b1) begin
            failures++;
            $display("FAIL reach_reset_state got_state=%0d rp_reset=%b want_state=4 rp_reset=1", state_o, rp_reset_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 41'd0) begin
            failures++;
            $display("FAIL mid_reset_async got=%h want=0", dut_vec());
        end
        #2 rst_ni = 1'b1;
        tick();
        err_m = 1'b0; rc_m = 16'd0; tc_m = 16'd0;
        checks++;
        if (dut_vec() !== 41'd0) begin
            failures++;
            $display("FAIL mid_reset_idle got=%h want=0", dut_vec());
        end
        $display("reset_mid: async reset applied in RESET state after %0d cycles", i);
        run_seq(4, 0, 1'b0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_counters();
        logic [15:0] want_rc;
`ifdef ARIANE_DFX_CTRL_STATS_EN
        want_rc = 16'd1;
`else
        want_rc = 16'd0;
`endif
        checks++;
        if (reconfig_cnt_o !== want_rc || timeout_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL counters got_rc=%0d got_tc=%0d want_rc=%0d want_tc=0",
                     reconfig_cnt_o, timeout_cnt_o, want_rc);
        end
        $display("counters: reconfig_cnt=%0d timeout_cnt=%0d", reconfig_cnt_o, timeout_cnt_o);
    endtask

    initial begin
        test_reset();
        run_seq(6, 3, 1'b0, 1'b0, 1'b0, "normal");
        run_seq(0, 0, 1'b0, 1'b0, 1'b0, "timeout");
        test_err_clr();
        run_seq(0, 1, 1'b0, 1'b0, 1'b1, "timeout_clr_race");
        test_err_clr();
        run_seq(TO, 0, 1'b0, 1'b0, 1'b0, "ack_at_zero");
        run_seq(2, 1, 1'b1, 1'b0, 1'b0, "done_filter");
        run_seq(3, 0, 1'b0, 1'b1, 1'b0, "back_to_back_1");
        run_seq(1, 2, 1'b0, 1'b0, 1'b0, "back_to_back_2");
        test_reset_mid();
        test_counters();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
